// File: rtl/br_wb_ctrl_pkg.sv
// Shared widths and requester identifiers for the BR write-back controller.
package br_pkg;

    localparam int unsigned AW   = 5;
    localparam int unsigned DWID = 32;
    localparam int unsigned NREG = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/br_wb_ctrl_arb.sv
// Two-request round-robin arbiter; the requester other than LAST wins a tie.
module rr_arb2
    import br_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o
);

    req_id_e    last_q, last_d;
    logic [1:0] gnt;

    // LAST resets to B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        unique case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == REQ_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            last_d = REQ_A;
        end else if (gnt[1]) begin
            last_d = REQ_B;
        end
    end

    assign gnt_c_o = gnt;

endmodule

// File: rtl/br_wb_ctrl.sv
// BR write-back controller: arbitrates A/B onto BR's write port and keeps the
// pending-write scoreboard that gates issue and flags read hazards.
module br_wb_ctrl
    import br_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_v_i,
    input  logic [AW-1:0]   iss_wa_i,
    output logic            iss_rdy_c_o,
    input  logic            a_v_i,
    input  logic [AW-1:0]   a_wa_i,
    input  logic [DWID-1:0] a_dw_i,
    output logic            a_rdy_c_o,
    input  logic            b_v_i,
    input  logic [AW-1:0]   b_wa_i,
    input  logic [DWID-1:0] b_dw_i,
    output logic            b_rdy_c_o,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic            haz1_c_o,
    output logic            haz2_c_o,
    output logic            we_o,
    output logic [AW-1:0]   wa_o,
    output logic [DWID-1:0] dw_o,
    output logic [NREG-1:0] pend_o
);

    logic [1:0]      gnt;
    logic            xfer;
    logic            iss_acc;
    logic [AW-1:0]   sel_wa;
    logic [DWID-1:0] sel_dw;

    logic            we_q, we_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [DWID-1:0] dw_q, dw_d;
    logic [NREG-1:0] pend_q, pend_d;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   ({b_v_i, a_v_i}),
        .gnt_c_o (gnt)
    );

    assign xfer    = |gnt;
    assign sel_wa  = gnt[0] ? a_wa_i : b_wa_i;
    assign sel_dw  = gnt[0] ? a_dw_i : b_dw_i;
    assign iss_acc = iss_v_i & ~pend_q[iss_wa_i];

    // Clear applied before set so a same-register issue keeps the bit pending.
    always_comb begin
        we_d   = xfer;
        wa_d   = wa_q;
        dw_d   = dw_q;
        pend_d = pend_q;
        if (xfer) begin
            wa_d           = sel_wa;
            dw_d           = sel_dw;
            pend_d[sel_wa] = 1'b0;
        end
        if (iss_acc) begin
            pend_d[iss_wa_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            wa_q   <= '0;
            dw_q   <= '0;
            pend_q <= '0;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            dw_q   <= dw_d;
            pend_q <= pend_d;
        end
    end

    assign iss_rdy_c_o = ~pend_q[iss_wa_i];
    assign a_rdy_c_o   = gnt[0];
    assign b_rdy_c_o   = gnt[1];
    assign haz1_c_o    = pend_q[ra1_i];
    assign haz2_c_o    = pend_q[ra2_i];
    assign we_o        = we_q;
    assign wa_o        = wa_q;
    assign dw_o        = dw_q;
    assign pend_o      = pend_q;

endmodule
